// File: rtl/maverickOne_pkg.sv
// Shared core-wide types and constants for the maverickOne pipeline.
// Holds the register lock bitmap type shared by the launcher and the writeback arbiter.
package maverickOne_pkg;

   localparam int NUM_REGS     = 32;
   localparam int XLEN         = 64;
   localparam int RIDX_W       = $clog2(NUM_REGS);
   localparam int NUM_WB_PORTS = 4;

   typedef logic [NUM_REGS-1:0] locks_t;

   typedef struct packed {
      logic [RIDX_W-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   // Register 0 is hardwired to zero: it is never locked and never written.
   function automatic logic is_x0(input logic [RIDX_W-1:0] rd);
      return (rd == '0);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: combinational one-hot grant searched from a
// rotating pointer, pointer advances past the winner when advance_i is high.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             clear_i,
   input  logic [N-1:0]     req_i,
   input  logic             advance_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] ptr_p0;
   logic [IDX_W-1:0] cand;
   logic             found;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
      return (i == LAST) ? '0 : i + IDX_W'(1);
   endfunction

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = ptr_p0;
      for (int k = 0; k < N; k++) begin
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            gnt_o[cand]  = 1'b1;
            gnt_idx_o    = cand;
         end
         cand = wrap_inc(cand);
      end
   end

   // pointer stage: next search begins just after the most recent winner
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         ptr_p0 <= '0;
      end else if (clear_i) begin
         ptr_p0 <= '0;
      end else if (advance_i) begin
         ptr_p0 <= wrap_inc(gnt_idx_o);
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin access to the single regfile write port, plus the
// register lock scoreboard that the instruction launcher consults before issue.
module wb_arbiter
   import maverickOne_pkg::*;
#(
   parameter int NUM_REQ  = NUM_WB_PORTS,
   parameter int XLEN     = 64,
   parameter int NUM_REGS = maverickOne_pkg::NUM_REGS,
   parameter int RIDX_W   = $clog2(NUM_REGS)
) (
   input  logic                           clk_i,
   input  logic                           arst_i,
   input  logic                           clear_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ-1:0][RIDX_W-1:0] req_rd_i,
   input  logic [NUM_REQ-1:0][XLEN-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   input  logic                           lock_set_valid_i,
   input  logic [RIDX_W-1:0]              lock_set_rd_i,
   output logic [NUM_REGS-1:0]            locks_o,
   output logic                           wr_en_o,
   output logic [RIDX_W-1:0]              wr_addr_o,
   output logic [XLEN-1:0]                wr_data_o,
   output logic                           err_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]  arb_req;
   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic                granted;
   logic [RIDX_W-1:0]   sel_rd;
   logic [XLEN-1:0]     sel_data;
   logic                wb_hit;
   logic                set_hit;
   logic                waw_err;
   logic                stale_err;
   logic [NUM_REGS-1:0] locks_nxt;

   logic                wr_en_p1;
   logic [RIDX_W-1:0]   wr_addr_p1;
   logic [XLEN-1:0]     wr_data_p1;
   logic [NUM_REGS-1:0] locks_p1;
   logic                err_p1;

   // No grant may be offered while flushing or held in reset.
   assign arb_req = (clear_i || arst_i) ? '0 : req_valid_i;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .clk_i     (clk_i),
      .arst_i    (arst_i),
      .clear_i   (clear_i),
      .req_i     (arb_req),
      .advance_i (granted),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign req_ready_o = gnt;
   assign granted     = |gnt;
   assign sel_rd      = req_rd_i[gnt_idx];
   assign sel_data    = req_data_i[gnt_idx];
   assign wb_hit      = granted && (sel_rd != '0);
   assign set_hit     = lock_set_valid_i && (lock_set_rd_i != '0);

   // A set on a register that is being released in the same cycle is a legal
   // hand-over to the new producer, not a WAW hazard.
   assign waw_err   = set_hit && locks_p1[lock_set_rd_i] &&
                      !(wb_hit && (sel_rd == lock_set_rd_i));
   assign stale_err = wb_hit && !locks_p1[sel_rd];

   always_comb begin
      locks_nxt = locks_p1;
      if (wb_hit) begin
         locks_nxt[sel_rd] = 1'b0;
      end
      if (set_hit) begin
         locks_nxt[lock_set_rd_i] = 1'b1;
      end
      locks_nxt[0] = 1'b0;
   end

   // write-port stage: grant registered into the regfile write and the lock bitmap
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_en_p1   <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
         locks_p1   <= '0;
         err_p1     <= 1'b0;
      end else if (clear_i) begin
         wr_en_p1   <= 1'b0;
         locks_p1   <= '0;
         err_p1     <= 1'b0;
      end else begin
         wr_en_p1 <= wb_hit;
         if (granted) begin
            wr_addr_p1 <= sel_rd;
            wr_data_p1 <= sel_data;
         end
         locks_p1 <= locks_nxt;
         err_p1   <= err_p1 | waw_err | stale_err;
      end
   end

   assign wr_en_o   = wr_en_p1;
   assign wr_addr_o = wr_addr_p1;
   assign wr_data_o = wr_data_p1;
   assign locks_o   = locks_p1;
   assign err_o     = err_p1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of arbitration, write port and lock scoreboard.
module tb_wb_arbiter;

   logic            clk_i = 1'b0;
   logic            arst_i;
   logic            clear_i;
   logic [3:0]      req_valid_i;
   logic [3:0][4:0] req_rd_i;
   logic [3:0][63:0] req_data_i;
   logic [3:0]      req_ready_o;
   logic            lock_set_valid_i;
   logic [4:0]      lock_set_rd_i;
   logic [31:0]     locks_o;
   logic            wr_en_o;
   logic [4:0]      wr_addr_o;
   logic [63:0]     wr_data_o;
   logic            err_o;

   int checks = 0;
   int errors = 0;

   int          m_ptr;
   logic [31:0] m_locks;
   logic        m_err;
   logic        m_wen;
   logic [4:0]  m_waddr;
   logic [63:0] m_wdata;

   wb_arbiter #(.NUM_REQ(4), .XLEN(64), .NUM_REGS(32), .RIDX_W(5)) dut (
      .clk_i            (clk_i),
      .arst_i           (arst_i),
      .clear_i          (clear_i),
      .req_valid_i      (req_valid_i),
      .req_rd_i         (req_rd_i),
      .req_data_i       (req_data_i),
      .req_ready_o      (req_ready_o),
      .lock_set_valid_i (lock_set_valid_i),
      .lock_set_rd_i    (lock_set_rd_i),
      .locks_o          (locks_o),
      .wr_en_o          (wr_en_o),
      .wr_addr_o        (wr_addr_o),
      .wr_data_o        (wr_data_o),
      .err_o            (err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int model_grant();
      int idx;
      if (arst_i || clear_i) return -1;
      for (int k = 0; k < 4; k++) begin
         idx = (m_ptr + k) % 4;
         if (req_valid_i[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready();
      logic [3:0] e;
      int g;
      e = '0;
      g = model_grant();
      if (g >= 0) e[g[1:0]] = 1'b1;
      return e;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_locks = '0; m_err = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
   endtask

   task automatic model_edge();
      int g;
      logic [31:0] nl;
      logic [4:0] rd;
      g = model_grant();
      if (clear_i) begin
         m_locks = '0; m_wen = 1'b0; m_err = 1'b0; m_ptr = 0;
      end else begin
         nl = m_locks;
         rd = '0;
         m_wen = 1'b0;
         if (g >= 0) begin
            rd = req_rd_i[g[1:0]];
            m_ptr = (g + 1) % 4;
            m_waddr = rd;
            m_wdata = req_data_i[g[1:0]];
            if (rd != 0) begin
               m_wen = 1'b1;
               if (!m_locks[rd]) m_err = 1'b1;
               nl[rd] = 1'b0;
            end
         end
         if (lock_set_valid_i && lock_set_rd_i != 0) begin
            if (m_locks[lock_set_rd_i] && !(g >= 0 && rd == lock_set_rd_i)) m_err = 1'b1;
            nl[lock_set_rd_i] = 1'b1;
         end
         m_locks = nl;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic drive_idle();
      req_valid_i = '0; lock_set_valid_i = 1'b0; lock_set_rd_i = '0; clear_i = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk_i);
      drive_idle();
      clear_i = 1'b1;
      tick();
      @(negedge clk_i);
      clear_i = 1'b0;
   endtask

   task automatic test_reset();
      arst_i = 1'b1;
      model_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         req_valid_i = 4'($urandom); lock_set_valid_i = 1'($urandom); lock_set_rd_i = 5'($urandom);
         clear_i = 1'b0;
         for (int u = 0; u < 4; u++) begin
            req_rd_i[u] = 5'($urandom); req_data_i[u] = {$urandom, $urandom};
         end
         #1;
         checks++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready_o); end
         @(posedge clk_i); #1;
         checks++;
         if (locks_o !== 32'b0 || wr_en_o !== 1'b0 || err_o !== 1'b0 || wr_addr_o !== 5'b0 || wr_data_o !== 64'b0) begin
            errors++;
            $display("FAIL reset_state got locks=%h wen=%b err=%b addr=%0d data=%h want all zero", locks_o, wr_en_o, err_o, wr_addr_o, wr_data_o);
         end
      end
      @(negedge clk_i);
      arst_i = 1'b0;
      drive_idle();
   endtask

   task automatic test_single();
      req_valid_i = 4'b0100; req_rd_i[2] = 5'd5; req_data_i[2] = 64'hAB;
      #1;
      checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready_o); end
      tick();
      checks++;
      if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd5 || wr_data_o !== 64'hAB) begin
         errors++; $display("FAIL single_write got wen=%b addr=%0d data=%h want 1/5/ab", wr_en_o, wr_addr_o, wr_data_o);
      end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL single_unlocked_err got %b want 1", err_o); end
      @(negedge clk_i);
      req_valid_i = '0;
   endtask

   task automatic test_fairness();
      logic [3:0] e;
      do_clear();
      req_valid_i = 4'b1111;
      for (int u = 0; u < 4; u++) req_rd_i[u] = 5'd0;
      for (int c = 0; c < 8; c++) begin
         e = 4'(1 << (c % 4));
         #1;
         checks++; if (req_ready_o !== e) begin errors++; $display("FAIL fair_order_%0d got %b want %b", c, req_ready_o, e); end
         tick();
         @(negedge clk_i);
      end
      req_valid_i = 4'b0001;
      tick();
      @(negedge clk_i);
      req_valid_i = 4'b1000;
      #1;
      checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL fair_only3 got %b want 1000", req_ready_o); end
      tick();
      @(negedge clk_i);
      req_valid_i = 4'b1001;
      #1;
      checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL fair_wrap got %b want 0001", req_ready_o); end
      tick();
      @(negedge clk_i);
      req_valid_i = '0;
   endtask

   task automatic test_lock_lifecycle();
      do_clear();
      lock_set_valid_i = 1'b1; lock_set_rd_i = 5'd7;
      tick();
      checks++; if (locks_o !== 32'h80) begin errors++; $display("FAIL lock_set7 got %h want 00000080", locks_o); end
      @(negedge clk_i);
      lock_set_valid_i = 1'b0;
      req_valid_i = 4'b0010; req_rd_i[1] = 5'd7; req_data_i[1] = 64'h1234_5678_9ABC_DEF0;
      #1;
      checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL lock_wb_ready got %b want 0010", req_ready_o); end
      tick();
      checks++;
      if (locks_o !== 32'h0 || wr_en_o !== 1'b1 || wr_addr_o !== 5'd7 || err_o !== 1'b0) begin
         errors++; $display("FAIL lock_clear7 got locks=%h wen=%b addr=%0d err=%b want 0/1/7/0", locks_o, wr_en_o, wr_addr_o, err_o);
      end
      @(negedge clk_i);
      req_valid_i = '0;
   endtask

   task automatic test_set_clear();
      do_clear();
      lock_set_valid_i = 1'b1; lock_set_rd_i = 5'd9;
      tick();
      @(negedge clk_i);
      req_valid_i = 4'b0001; req_rd_i[0] = 5'd9; req_data_i[0] = 64'h99;
      #1;
      tick();
      checks++;
      if (locks_o !== 32'h200 || wr_en_o !== 1'b1 || wr_addr_o !== 5'd9 || err_o !== 1'b0) begin
         errors++; $display("FAIL setclr9 got locks=%h wen=%b addr=%0d err=%b want 200/1/9/0", locks_o, wr_en_o, wr_addr_o, err_o);
      end
      @(negedge clk_i);
      drive_idle();
   endtask

   task automatic test_errors();
      do_clear();
      lock_set_valid_i = 1'b1; lock_set_rd_i = 5'd4;
      tick();
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_first_set got %b want 0", err_o); end
      @(negedge clk_i);
      tick();
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_waw got %b want 1", err_o); end
      @(negedge clk_i);
      lock_set_valid_i = 1'b0;
      tick();
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_o); end
      do_clear();
      req_valid_i = 4'b0100; req_rd_i[2] = 5'd12; req_data_i[2] = 64'hC0FFEE;
      tick();
      checks++;
      if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd12 || wr_data_o !== 64'hC0FFEE || err_o !== 1'b1) begin
         errors++; $display("FAIL err_unlocked12 got wen=%b addr=%0d data=%h err=%b want 1/12/c0ffee/1", wr_en_o, wr_addr_o, wr_data_o, err_o);
      end
      do_clear();
      lock_set_valid_i = 1'b1; lock_set_rd_i = 5'd0;
      tick();
      checks++; if (locks_o !== 32'h0) begin errors++; $display("FAIL x0_lock got %h want 0", locks_o); end
      @(negedge clk_i);
      lock_set_valid_i = 1'b0;
      req_valid_i = 4'b0001; req_rd_i[0] = 5'd0; req_data_i[0] = 64'h5;
      #1;
      checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL x0_ready got %b want 0001", req_ready_o); end
      tick();
      checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL x0_wen got %b want 0", wr_en_o); end
      @(negedge clk_i);
      req_valid_i = 4'b0011; req_rd_i[1] = 5'd0;
      #1;
      checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL x0_rotate got %b want 0010", req_ready_o); end
      tick();
      @(negedge clk_i);
      req_valid_i = '0;
   endtask

   task automatic test_flush();
      logic [4:0] regs [9];
      regs = '{5'd4, 5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};
      do_clear();
      for (int i = 0; i < 9; i++) begin
         lock_set_valid_i = 1'b1; lock_set_rd_i = regs[i];
         tick();
         @(negedge clk_i);
      end
      lock_set_valid_i = 1'b0;
      req_valid_i = 4'b0001; req_rd_i[0] = 5'd0;
      tick();
      checks++;
      if (locks_o !== 32'h0000F0F0 || err_o !== 1'b1) begin
         errors++; $display("FAIL flush_pre got locks=%h err=%b want 0000f0f0/1", locks_o, err_o);
      end
      @(negedge clk_i);
      req_valid_i = 4'b1111;
      for (int u = 0; u < 4; u++) req_rd_i[u] = 5'(u + 4);
      lock_set_valid_i = 1'b1; lock_set_rd_i = 5'd1;
      clear_i = 1'b1;
      #1;
      checks++; if (req_ready_o !== 4'b0) begin errors++; $display("FAIL flush_ready got %b want 0000", req_ready_o); end
      tick();
      checks++;
      if (locks_o !== 32'h0 || wr_en_o !== 1'b0 || err_o !== 1'b0) begin
         errors++; $display("FAIL flush_state got locks=%h wen=%b err=%b want 0/0/0", locks_o, wr_en_o, err_o);
      end
      @(negedge clk_i);
      clear_i = 1'b0; lock_set_valid_i = 1'b0;
      #1;
      checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL flush_rr_restart got %b want 0001", req_ready_o); end
      tick();
      @(negedge clk_i);
      req_valid_i = '0;
   endtask

   task automatic test_async_reset();
      do_clear();
      lock_set_valid_i = 1'b1; lock_set_rd_i = 5'd3;
      tick();
      @(negedge clk_i);
      lock_set_rd_i = 5'd6;
      tick();
      @(negedge clk_i);
      lock_set_valid_i = 1'b0;
      req_valid_i = 4'b0010; req_rd_i[1] = 5'd3; req_data_i[1] = 64'h77;
      tick();
      req_valid_i = 4'b0100; req_rd_i[2] = 5'd6;
      #2;
      arst_i = 1'b1;
      #1;
      checks++;
      if (wr_en_o !== 1'b0 || locks_o !== 32'h0 || req_ready_o !== 4'b0 || wr_addr_o !== 5'd0 || wr_data_o !== 64'h0) begin
         errors++; $display("FAIL async_reset got wen=%b locks=%h ready=%b addr=%0d data=%h want all zero", wr_en_o, locks_o, req_ready_o, wr_addr_o, wr_data_o);
      end
      @(negedge clk_i);
      arst_i = 1'b0;
      model_reset();
      drive_idle();
   endtask

   task automatic test_random();
      int g;
      logic [3:0] e;
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < 4; u++) begin
            if (!req_valid_i[u] && ($urandom_range(0, 1) == 1)) begin
               req_valid_i[u] = 1'b1;
               req_rd_i[u] = 5'($urandom_range(0, 31));
               req_data_i[u] = {$urandom, $urandom};
            end
         end
         lock_set_valid_i = ($urandom_range(0, 2) == 0);
         lock_set_rd_i = 5'($urandom_range(0, 31));
         clear_i = ($urandom_range(0, 39) == 0);
         #1;
         e = model_ready();
         g = model_grant();
         checks++; if (req_ready_o !== e) begin errors++; $display("FAIL rand_ready_%0d got %b want %b", c, req_ready_o, e); end
         tick();
         checks++;
         if (wr_en_o !== m_wen || wr_addr_o !== m_waddr || wr_data_o !== m_wdata || locks_o !== m_locks || err_o !== m_err) begin
            errors++;
            $display("FAIL rand_state_%0d got wen=%b addr=%0d data=%h locks=%h err=%b want %b/%0d/%h/%h/%b",
                     c, wr_en_o, wr_addr_o, wr_data_o, locks_o, err_o, m_wen, m_waddr, m_wdata, m_locks, m_err);
         end
         @(negedge clk_i);
         if (g >= 0) req_valid_i[g[1:0]] = 1'b0;
      end
      drive_idle();
   endtask

   initial begin
      arst_i = 1'b1;
      drive_idle();
      for (int u = 0; u < 4; u++) begin
         req_rd_i[u] = '0; req_data_i[u] = '0;
      end
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_lock_lifecycle();
      test_set_clear();
      test_errors();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
